sprite_pos_sched: RTL and testbench

// - Collects sprite position updates from two requesters (physics engine, cue/stick control) via valid/ready handshakes.
// - Round-robin arbitrates them into a shadow position table.
// - Copies the shadow table into the live table at each vertical-blank entry, so the blitter never sees a torn frame.
// - Live table feeds the blitter's per-sprite x/y inputs (15 balls, cue ball, pool cue).

---
 rtl/sprite_pkg.sv | 27 ++
 rtl/rr_arb2.sv | 31 +++
 rtl/sprite_pos_sched.sv | 140 ++++++++++++++
 tb/tb_sprite_pos_sched.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared sizes, ids and types for the sprite position scheduler
package sprite_pkg;

    localparam int NUM_SPRITES = 17;
    localparam int COORD_W     = 10;
    localparam int ID_W        = 5;

    localparam logic [COORD_W-1:0] HIDDEN   = 10'h3FF;
    localparam logic [ID_W-1:0]    LAST_IDX = ID_W'(NUM_SPRITES - 1);

    typedef enum logic [ID_W-1:0] {
        BALL1 = 5'd0, BALL2, BALL3, BALL4, BALL5, BALL6, BALL7, BALL8,
        BALL9, BALL10, BALL11, BALL12, BALL13, BALL14, BALL15,
        CUE_BALL, POOL_CUE
    } sprite_id_t;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } pos_t;

    typedef enum logic {
        IDLE   = 1'b0,
        COMMIT = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter; the pointer moves to the loser after each advancing grant
module rr_arb2 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] valid,
    input  logic       advance,
    output logic [1:0] grant
);

    logic r_ptr;

    always_comb begin
        grant = 2'b00;
        if (!r_ptr) begin
            if (valid[0])      grant = 2'b01;
            else if (valid[1]) grant = 2'b10;
        end else begin
            if (valid[1])      grant = 2'b10;
            else if (valid[0]) grant = 2'b01;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr <= 1'b0;
        end else if (advance && (|grant)) begin
            r_ptr <= grant[0];
        end
    end

endmodule

// File: rtl/sprite_pos_sched.sv
// rtl/sprite_pos_sched.sv - arbitrated shadow position table copied to the live table on vblank entry
// Optional: SPRITE_SCHED_COALESCE_EN acks both requesters in one cycle when their ids match.
module sprite_pos_sched
    import sprite_pkg::*;
(
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                vblank,
    input  logic                                req0_valid,
    output logic                                req0_ready,
    input  logic [ID_W-1:0]                     req0_id,
    input  logic [COORD_W-1:0]                  req0_x,
    input  logic [COORD_W-1:0]                  req0_y,
    input  logic                                req1_valid,
    output logic                                req1_ready,
    input  logic [ID_W-1:0]                     req1_id,
    input  logic [COORD_W-1:0]                  req1_x,
    input  logic [COORD_W-1:0]                  req1_y,
    output logic [NUM_SPRITES-1:0][COORD_W-1:0] pos_x,
    output logic [NUM_SPRITES-1:0][COORD_W-1:0] pos_y,
    output logic                                busy,
    output logic                                commit_done,
    output logic                                id_err
);

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_vblank_q;
    logic [ID_W-1:0] r_idx;
    logic            r_commit_done;
    logic            r_id_err;
    pos_t            r_shadow [NUM_SPRITES];
    pos_t            r_live   [NUM_SPRITES];

    logic            w_rise;
    logic            w_last;
    logic            w_accept_en;
    logic [1:0]      w_valid;
    logic [1:0]      w_grant;
    logic [1:0]      w_ack;
    logic            w_advance;
    logic            w_wr_en;
    logic            w_wr_ok;
    logic [ID_W-1:0] w_wr_id;
    pos_t            w_wr_pos;

    assign w_rise  = vblank & ~r_vblank_q;
    assign w_last  = (r_idx == LAST_IDX);
    assign w_valid = {req1_valid, req0_valid} & {2{w_accept_en}};

    rr_arb2 u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .valid   (w_valid),
        .advance (w_advance),
        .grant   (w_grant)
    );

`ifdef SPRITE_SCHED_COALESCE_EN
    logic w_coalesce;
    assign w_coalesce = (w_valid == 2'b11) && (req0_id == req1_id);
    assign w_ack      = w_coalesce ? 2'b11 : w_grant;
    assign w_advance  = ~w_coalesce;
`else
    assign w_ack      = w_grant;
    assign w_advance  = 1'b1;
`endif

    // req1 wins the data mux so a coalesced pair writes req1's position
    assign req0_ready = w_ack[0];
    assign req1_ready = w_ack[1];
    assign w_wr_en    = |w_ack;
    assign w_wr_id    = w_ack[1] ? req1_id : req0_id;
    assign w_wr_pos   = w_ack[1] ? pos_t'{x: req1_x, y: req1_y} : pos_t'{x: req0_x, y: req0_y};
    assign w_wr_ok    = (w_wr_id < ID_W'(NUM_SPRITES));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_rise) w_state_nxt = COMMIT;
            COMMIT:  if (w_last) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy        = (r_state == COMMIT);
        w_accept_en = (r_state == IDLE);
    end

    // vblank_q resets high so a vblank already asserted at release is not a rise
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vblank_q    <= 1'b1;
            r_idx         <= '0;
            r_commit_done <= 1'b0;
            r_id_err      <= 1'b0;
        end else begin
            r_vblank_q    <= vblank;
            r_commit_done <= (r_state == COMMIT) && w_last;
            r_idx         <= (r_state == COMMIT) ? r_idx + 1'b1 : '0;
            if (w_wr_en && !w_wr_ok) r_id_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_SPRITES; i++) r_shadow[i] <= '{x: HIDDEN, y: HIDDEN};
        end else if (w_wr_en && w_wr_ok) begin
            r_shadow[w_wr_id] <= w_wr_pos;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_SPRITES; i++) r_live[i] <= '{x: HIDDEN, y: HIDDEN};
        end else if (r_state == COMMIT) begin
            r_live[r_idx] <= r_shadow[r_idx];
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_SPRITES; i++) begin
            pos_x[i] = r_live[i].x;
            pos_y[i] = r_live[i].y;
        end
    end

    assign commit_done = r_commit_done;
    assign id_err      = r_id_err;

endmodule

// File: tb/tb_sprite_pos_sched.sv
// tb/tb_sprite_pos_sched.sv - directed self-checking bench for sprite_pos_sched
module tb_sprite_pos_sched;
    import sprite_pkg::*;

    logic                                clk = 1'b0;
    logic                                reset_n;
    logic                                vblank;
    logic                                req0_valid, req0_ready;
    logic [ID_W-1:0]                     req0_id;
    logic [COORD_W-1:0]                  req0_x, req0_y;
    logic                                req1_valid, req1_ready;
    logic [ID_W-1:0]                     req1_id;
    logic [COORD_W-1:0]                  req1_x, req1_y;
    logic [NUM_SPRITES-1:0][COORD_W-1:0] pos_x, pos_y;
    logic                                busy, commit_done, id_err;

    logic [COORD_W-1:0] exp_x [NUM_SPRITES];
    logic [COORD_W-1:0] exp_y [NUM_SPRITES];
    int n_total = 0;
    int n_bad   = 0;
    int lat, pulses, cnt;
    logic [1:0] pat [4];

    always #5 clk = ~clk;

    sprite_pos_sched dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .vblank      (vblank),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_id     (req0_id),
        .req0_x      (req0_x),
        .req0_y      (req0_y),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_id     (req1_id),
        .req1_x      (req1_x),
        .req1_y      (req1_y),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .busy        (busy),
        .commit_done (commit_done),
        .id_err      (id_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_table(input string tag);
        int bad = 0;
        for (int i = 0; i < NUM_SPRITES; i++)
            if (pos_x[i] !== exp_x[i] || pos_y[i] !== exp_y[i]) bad++;
        check(tag, 32'(bad), 32'd0);
    endtask

    task automatic set_hidden();
        for (int i = 0; i < NUM_SPRITES; i++) begin
            exp_x[i] = HIDDEN;
            exp_y[i] = HIDDEN;
        end
    endtask

    // raise vblank, count commit_done pulses over 40 cycles, record latency from the rise edge
    task automatic run_frame(output int o_lat, output int o_pulses);
        o_lat = -1;
        o_pulses = 0;
        vblank = 1'b1;
        tick();
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (commit_done === 1'b1) begin
                o_pulses++;
                if (o_lat < 0) o_lat = k;
            end
        end
        vblank = 1'b0;
        tick();
    endtask

    initial begin
        reset_n = 1'b0; vblank = 1'b0;
        req0_valid = 1'b0; req0_id = '0; req0_x = '0; req0_y = '0;
        req1_valid = 1'b0; req1_id = '0; req1_x = '0; req1_y = '0;
        set_hidden();
        repeat (3) tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(commit_done), 32'd0);
        check("rst_iderr", 32'(id_err), 32'd0);
        check_table("rst_table");
        reset_n = 1'b1;
        repeat (2) tick();

        for (int f = 0; f < 3; f++) begin
            run_frame(lat, pulses);
            check($sformatf("idle_frame%0d_pulses", f), 32'(pulses), 32'd1);
        end
        check("idle_frames_lat", 32'(lat), 32'd17);
        check_table("idle_frames_table");
        check("idle_frames_iderr", 32'(id_err), 32'd0);

        req0_valid = 1'b1; req0_id = BALL1; req0_x = 10'd100; req0_y = 10'd200;
        #1 check("w0_ready", 32'(req0_ready), 32'd1);
        tick();
        req0_valid = 1'b0;
        check("w0_live_before_rise", 32'(pos_x[0]), 32'h3FF);
        vblank = 1'b1;
        tick();
        check("w0_busy", 32'(busy), 32'd1);
        check("w0_live_before_copy", 32'(pos_x[0]), 32'h3FF);
        tick();
        check("w0_live_x_after", 32'(pos_x[0]), 32'd100);
        check("w0_live_y_after", 32'(pos_y[0]), 32'd200);
        exp_x[0] = 10'd100; exp_y[0] = 10'd200;
        lat = -1;
        for (int k = 2; k <= 40; k++) begin
            tick();
            if (commit_done === 1'b1 && lat < 0) lat = k;
        end
        check("w0_done_latency", 32'(lat), 32'd17);
        vblank = 1'b0;
        tick();

        pat[0] = 2'b10; pat[1] = 2'b01; pat[2] = 2'b10; pat[3] = 2'b01;
        req0_valid = 1'b1; req0_id = BALL4; req0_x = 10'd30; req0_y = 10'd31;
        req1_valid = 1'b1; req1_id = BALL5; req1_x = 10'd40; req1_y = 10'd41;
        for (int i = 0; i < 4; i++) begin
            #1 check($sformatf("alt%0d", i), 32'({req1_ready, req0_ready}), 32'(pat[i]));
            tick();
        end
        req1_valid = 1'b0;
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            #1 if (req0_ready === 1'b1) cnt++;
            tick();
        end
        check("lone_req0", 32'(cnt), 32'd3);
        req0_valid = 1'b0; req1_valid = 1'b1;
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            #1 if (req1_ready === 1'b1) cnt++;
            tick();
        end
        check("lone_req1", 32'(cnt), 32'd3);
        req1_valid = 1'b0;
        exp_x[3] = 10'd30; exp_y[3] = 10'd31;
        exp_x[4] = 10'd40; exp_y[4] = 10'd41;

        req0_valid = 1'b1; req0_id = CUE_BALL; req0_x = 10'd10; req0_y = 10'd10;
        req1_valid = 1'b1; req1_id = CUE_BALL; req1_x = 10'd20; req1_y = 10'd20;
`ifdef SPRITE_SCHED_COALESCE_EN
        #1 check("same_id_both", 32'({req1_ready, req0_ready}), 32'd3);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
`else
        #1 check("same_id_first", 32'({req1_ready, req0_ready}), 32'd1);
        tick();
        req0_valid = 1'b0;
        #1 check("same_id_second", 32'({req1_ready, req0_ready}), 32'd2);
        tick();
        req1_valid = 1'b0;
`endif
        exp_x[15] = 10'd20; exp_y[15] = 10'd20;
        run_frame(lat, pulses);
        check("same_id_pulses", 32'(pulses), 32'd1);
        check_table("same_id_table");

        vblank = 1'b1;
        req1_valid = 1'b1; req1_id = BALL8; req1_x = 10'd70; req1_y = 10'd71;
        #1 check("rise_w_ready", 32'(req1_ready), 32'd1);
        tick();
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_id = BALL9; req0_x = 10'd80; req0_y = 10'd81;
        cnt = 0;
        for (int k = 0; k < 17; k++) begin
            if (req0_ready !== 1'b0 || busy !== 1'b1) cnt++;
            tick();
        end
        check("commit_blocks_ready", 32'(cnt), 32'd0);
        check("commit_done_pulse", 32'(commit_done), 32'd1);
        check("post_commit_ready", 32'(req0_ready), 32'd1);
        exp_x[7] = 10'd70; exp_y[7] = 10'd71;
        check_table("rise_w_table");
        tick();
        req0_valid = 1'b0; vblank = 1'b0;
        check("held_not_live", 32'(pos_x[8]), 32'h3FF);
        tick();
        run_frame(lat, pulses);
        exp_x[8] = 10'd80; exp_y[8] = 10'd81;
        check_table("held_table");

        req0_valid = 1'b1; req0_id = 5'd20; req0_x = 10'd5; req0_y = 10'd6;
        #1 check("bad_id_ready", 32'(req0_ready), 32'd1);
        tick();
        req0_valid = 1'b0;
        check("bad_id_err", 32'(id_err), 32'd1);
        run_frame(lat, pulses);
        check("bad_id_err_sticky", 32'(id_err), 32'd1);
        check_table("bad_id_table");

        vblank = 1'b1;
        tick();
        repeat (8) tick();
        check("mid_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        set_hidden();
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_iderr", 32'(id_err), 32'd0);
        check_table("mid_rst_table");
        repeat (2) tick();
        reset_n = 1'b1;
        cnt = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (busy !== 1'b0) cnt++;
        end
        check("vblank_high_release", 32'(cnt), 32'd0);
        vblank = 1'b0;
        tick();
        run_frame(lat, pulses);
        check("after_rst_pulses", 32'(pulses), 32'd1);
        check("after_rst_lat", 32'(lat), 32'd17);
        check_table("after_rst_table");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
